// File: rtl/ewb_pkg.sv
// ---------------------------------------------------------------------------
// ewb_pkg : shared types and default widths for the eviction write buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ewb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [LINE_W_DEF-1:0] data;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/ewb_cam.sv
// ---------------------------------------------------------------------------
// ewb_cam : DEPTH-way address compare against valid buffer entries
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ewb_cam
  import ewb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = 2
) (
  input  logic [ADDR_W-1:0] key,
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  output logic              hit,
  output logic [DEPTH-1:0]  match,
  output logic [IDX_W-1:0]  idx
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid[i] && (addrs[i] == key);
  end

  assign hit = |match;

  // Coalescing keeps match one-hot, so OR-ing indices is a valid encoder.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ewb_multi.sv
// ---------------------------------------------------------------------------
// ewb_multi : multi-entry FIFO eviction write buffer between L2 and memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ewb_multi
  import ewb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int IDLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_rdata,
  input  logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  input  logic              flush,
  output logic              empty,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDL_W = $clog2(IDLE_CYC + 1);

  state_t             state, state_n;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [IDL_W-1:0]   idle_cnt;
  logic [DEPTH-1:0]   valid;
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [LINE_W-1:0]  data_q [DEPTH];

  logic               hit;
  logic [DEPTH-1:0]   match;
  logic [PTR_W-1:0]   hit_idx;

  logic full, drain_done, head_hit_drain;
  logic write_merge, write_alloc, read_hit, read_miss, idle_full;

  ewb_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (PTR_W)
  ) u_cam (
    .key   (mem_address),
    .valid (valid),
    .addrs (addr_q),
    .hit   (hit),
    .match (match),
    .idx   (hit_idx)
  );

  assign full           = (count == CNT_W'(DEPTH));
  assign empty          = (count == '0);
  assign idle_full      = (idle_cnt == IDL_W'(IDLE_CYC));
  assign drain_done     = (state == ST_DRAIN) && pmem_resp;
  assign head_hit_drain = (state == ST_DRAIN) && hit && (hit_idx == head);
  assign read_hit       = mem_read && hit;
  assign read_miss      = mem_read && !hit;
  assign write_merge    = mem_write && hit && !head_hit_drain;
  // A write aimed at the line being drained waits for the drain and then
  // re-enters as a fresh allocation; the freed slot makes room even when full.
  assign write_alloc    = mem_write && !write_merge &&
                          (!head_hit_drain || drain_done) && (!full || drain_done);

  always_comb begin
    state_n      = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      ST_IDLE: begin
        if (read_miss && !full)
          state_n = ST_PASS;
        else if (!empty && (full || idle_full || flush))
          state_n = ST_DRAIN;
      end
      ST_PASS: begin
        pmem_read    = 1'b1;
        pmem_address = mem_address;
        mem_rdata    = pmem_rdata;
        mem_resp     = pmem_resp;
        if (pmem_resp) state_n = ST_IDLE;
      end
      ST_DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = addr_q[head];
        pmem_wdata   = data_q[head];
        if (pmem_resp) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (read_hit) begin
      mem_rdata = data_q[hit_idx];
      mem_resp  = 1'b1;
    end
    if (write_merge || write_alloc) mem_resp = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      idle_cnt <= '0;
      valid    <= '0;
    end else begin
      state <= state_n;
      if (mem_read || mem_write)
        idle_cnt <= '0;
      else if (!idle_full)
        idle_cnt <= idle_cnt + 1'b1;
      // Clear before set: when full, tail aliases the head slot being freed.
      if (drain_done) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (write_alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (write_alloc && !drain_done)
        count <= count + 1'b1;
      else if (!write_alloc && drain_done)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (write_alloc && (tail == PTR_W'(i))) begin
        addr_q[i] <= mem_address;
        data_q[i] <= mem_wdata;
      end else if (write_merge && match[i]) begin
        data_q[i] <= mem_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ewb_multi.sv
// ---------------------------------------------------------------------------
// tb_ewb_multi : self-checking bench for ewb_multi (FIFO-queue reference model)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ewb_multi;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int IDLE  = 2;
  localparam logic [LW-1:0] D0  = {8{32'hD0D0_0000}};
  localparam logic [LW-1:0] D1A = {8{32'hD1D1_000A}};
  localparam logic [LW-1:0] D1B = {8{32'hD1D1_000B}};
  localparam logic [LW-1:0] DA  = {8{32'hDADA_0040}};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_address = '0;
  logic [LW-1:0] mem_rdata;
  logic [LW-1:0] mem_wdata = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          mem_resp;
  logic          flush = 1'b0;
  logic          empty;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_rdata = '0;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  ewb_multi #(
    .DEPTH(DEPTH), .ADDR_W(AW), .LINE_W(LW), .IDLE_CYC(IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .flush(flush), .empty(empty),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b @%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_d(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered lines in FIFO order plus the memory image.
  typedef struct { logic [AW-1:0] a; logic [LW-1:0] d; } ent_t;
  ent_t          q[$];
  logic [LW-1:0] mem_img [logic [AW-1:0]];

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = a ^ (32'h5A5A_0000 + 32'(i));
    return r;
  endfunction
  function automatic logic [LW-1:0] img(input logic [AW-1:0] a);
    return mem_img.exists(a) ? mem_img[a] : init_line(a);
  endfunction
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic int find_q(input logic [AW-1:0] a, input int from);
    for (int i = from; i < q.size(); i++) if (q[i].a == a) return i;
    return -1;
  endfunction

  // Memory responder: random or forced latency per transaction.
  int fixed_wait = -1;
  int wait_n = 0;
  bit active = 1'b0;
  always @(posedge clk) begin
    #1;
    if (pmem_resp || !(pmem_read || pmem_write)) begin
      pmem_resp = 1'b0;
      active    = 1'b0;
    end else begin
      if (!active) begin
        active = 1'b1;
        wait_n = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (wait_n == 0) begin
        pmem_resp = 1'b1;
        if (pmem_read) pmem_rdata = img(pmem_address);
      end else begin
        wait_n--;
      end
    end
  end

  // Monitor state shared with the directed sequence.
  int            cyc = 0;
  int            pw_cnt = 0;
  int            pr_cnt = 0;
  int            last_done_cyc = 0;
  int            last_pr_start_cyc = 0;
  logic [AW-1:0] last_pr_addr = '0;
  logic [LW-1:0] last_wdata = '0;
  logic [AW-1:0] drain_log[$];
  bit            prev_pr = 1'b0;

  always @(negedge clk) begin : cmp
    int   hi;
    int   wi;
    bit   drain_now;
    bit   busy;
    bit   exp_wr;
    ent_t e;
    cyc++;
    if (!rst) begin
      q.delete();
      prev_pr = 1'b0;
    end else begin
      assert (!(mem_read && mem_write)) else $error("illegal read+write request");
      chk_b("empty", empty, q.size() == 0);
      chk_b("strobe_overlap", pmem_read && pmem_write, 1'b0);
      if (pmem_write) begin
        chk_b("drain_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          chk_a("drain_addr", pmem_address, q[0].a);
          chk_d("drain_data", pmem_wdata, q[0].d);
        end
      end
      if (pmem_read) begin
        chk_a("pread_addr", pmem_address, mem_address);
        chk_b("pread_for_miss", mem_read && (find_q(mem_address, 0) < 0), 1'b1);
      end
      drain_now = pmem_write && pmem_resp;
      if (mem_read) begin
        hi = find_q(mem_address, 0);
        if (hi >= 0) begin
          chk_b("rd_hit_resp", mem_resp, 1'b1);
          chk_d("rd_hit_data", mem_rdata, q[hi].d);
        end else begin
          chk_b("rd_miss_resp", mem_resp, pmem_read && pmem_resp);
          if (mem_resp) chk_d("rd_miss_data", mem_rdata, img(mem_address));
        end
      end else if (mem_write) begin
        busy   = pmem_write && !pmem_resp && (q.size() > 0) && (q[0].a == mem_address);
        exp_wr = !busy && ((find_q(mem_address, drain_now ? 1 : 0) >= 0) ||
                           ((q.size() - (drain_now ? 1 : 0)) < DEPTH));
        chk_b("wr_resp", mem_resp, exp_wr);
      end else begin
        chk_b("idle_no_resp", mem_resp, 1'b0);
      end
      if (pmem_read && !prev_pr) begin
        last_pr_start_cyc = cyc;
        last_pr_addr      = pmem_address;
      end
      if (pmem_read) pr_cnt++;
      prev_pr = pmem_read;
      if (drain_now && q.size() > 0) begin
        mem_img[q[0].a] = q[0].d;
        drain_log.push_back(pmem_address);
        last_wdata    = pmem_wdata;
        last_done_cyc = cyc;
        pw_cnt++;
        void'(q.pop_front());
      end
      if (mem_write && mem_resp) begin
        wi = find_q(mem_address, 0);
        if (wi >= 0) q[wi].d = mem_wdata;
        else begin
          e.a = mem_address;
          e.d = mem_wdata;
          q.push_back(e);
        end
      end
    end
  end

  // L2-side drivers; all start and end at posedge+1.
  int resp_cyc = 0;
  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] d, output int lat);
    mem_address = a; mem_wdata = d; mem_write = 1'b1; lat = 0;
    forever begin
      @(negedge clk); #1;
      if (mem_resp) begin resp_cyc = cyc; break; end
      lat++;
      if (lat > 100) begin chk_b("wr_timeout", 1'b0, 1'b1); break; end
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask
  task automatic do_read(input logic [AW-1:0] a, output logic [LW-1:0] d, output int lat);
    mem_address = a; mem_read = 1'b1; lat = 0; d = '0;
    forever begin
      @(negedge clk); #1;
      if (mem_resp) begin d = mem_rdata; break; end
      lat++;
      if (lat > 100) begin chk_b("rd_timeout", 1'b0, 1'b1); break; end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty && n < 100) begin @(posedge clk); #1; n++; end
    chk_b(name, empty, 1'b1);
  endtask
  task automatic wait_pwrite(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!pmem_write && n < 40);
    chk_b(name, pmem_write, 1'b1);
  endtask

  initial begin : main
    int            lat;
    int            mark;
    int            pw0;
    int            pr0;
    logic [LW-1:0] d;
    logic [AW-1:0] a;
    logic [AW-1:0] exp3 [5];
    logic [AW-1:0] exp6 [3];
    exp3 = '{32'h000, 32'h020, 32'h040, 32'h060, 32'h080};
    exp6 = '{32'h400, 32'h420, 32'h440};

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_b("rst_empty", empty, 1'b1);
    chk_b("rst_mem_resp", mem_resp, 1'b0);
    chk_b("rst_pmem_read", pmem_read, 1'b0);
    chk_b("rst_pmem_write", pmem_write, 1'b0);
    chk_a("rst_pmem_addr", pmem_address, 32'h0);
    chk_d("rst_pmem_wdata", pmem_wdata, '0);
    chk_d("rst_mem_rdata", mem_rdata, '0);
    @(posedge clk); #1 rst = 1'b1;
    idle(1);

    // Single write, idle-window drain.
    do_write(32'h100, D0, lat);
    chk_i("t1_wr_lat", lat, 0);
    chk_b("t1_not_empty", empty, 1'b0);
    wait_pwrite("t1_drain_seen");
    chk_a("t1_drain_addr", pmem_address, 32'h100);
    chk_d("t1_drain_data", pmem_wdata, D0);
    @(posedge clk); #1;
    wait_empty("t1_empty_after");

    // Coalescing.
    pw0 = pw_cnt;
    do_write(32'h100, D1A, lat);
    do_write(32'h100, D1B, lat);
    chk_i("t2_merge_lat", lat, 0);
    wait_empty("t2_empty_after");
    idle(6);
    chk_i("t2_one_drain", pw_cnt - pw0, 1);
    chk_d("t2_drain_data", last_wdata, D1B);

    // Fill to full, then stalled write accepted on first drain completion.
    mark = drain_log.size();
    for (int i = 0; i < 4; i++) do_write(exp3[i], rnd_line(), lat);
    do_write(32'h080, rnd_line(), lat);
    chk_b("t3_stalled", lat != 0, 1'b1);
    chk_i("t3_accept_cycle", resp_cyc, last_done_cyc);
    chk_b("t3_first_drained", drain_log.size() > mark, 1'b1);
    if (drain_log.size() > mark) chk_a("t3_first_addr", drain_log[mark], 32'h000);
    flush = 1'b1;
    wait_empty("t3_flush_empty");
    flush = 1'b0;
    chk_i("t3_drain_count", drain_log.size() - mark, 5);
    for (int i = 0; i < 5; i++)
      if (mark + i < drain_log.size()) chk_a("t3_order", drain_log[mark+i], exp3[i]);

    // Read hit and read miss.
    do_write(32'h040, DA, lat);
    pr0 = pr_cnt;
    do_read(32'h040, d, lat);
    chk_d("t4_hit_data", d, DA);
    chk_i("t4_hit_lat", lat, 0);
    chk_i("t4_no_pread", pr_cnt - pr0, 0);
    do_read(32'h200, d, lat);
    chk_d("t4_miss_data", d, init_line(32'h200));
    chk_b("t4_miss_lat", lat != 0, 1'b1);
    chk_a("t4_pread_addr", last_pr_addr, 32'h200);

    // Read miss waits behind an in-flight drain.
    flush = 1'b1;
    wait_empty("t5_pre_empty");
    flush = 1'b0;
    fixed_wait = 4;
    do_write(32'h000, rnd_line(), lat);
    wait_pwrite("t5_drain_seen");
    @(posedge clk); #1;
    do_read(32'h300, d, lat);
    fixed_wait = -1;
    chk_b("t5_pread_after_drain", last_pr_start_cyc > last_done_cyc, 1'b1);
    chk_d("t5_miss_data", d, init_line(32'h300));

    // Flush drains FIFO order, then async reset mid-drain.
    wait_empty("t6_pre_empty");
    mark = drain_log.size();
    for (int i = 0; i < 3; i++) do_write(exp6[i], rnd_line(), lat);
    flush = 1'b1;
    wait_empty("t6_flush_empty");
    flush = 1'b0;
    chk_i("t6_drain_count", drain_log.size() - mark, 3);
    for (int i = 0; i < 3; i++)
      if (mark + i < drain_log.size()) chk_a("t6_order", drain_log[mark+i], exp6[i]);
    do_write(32'h500, rnd_line(), lat);
    fixed_wait = 6;
    flush = 1'b1;
    wait_pwrite("t6_rst_drain_seen");
    #2 rst = 1'b0;
    #1;
    chk_b("t6_rst_pwrite", pmem_write, 1'b0);
    chk_b("t6_rst_pread", pmem_read, 1'b0);
    chk_a("t6_rst_paddr", pmem_address, 32'h0);
    chk_d("t6_rst_pwdata", pmem_wdata, '0);
    chk_b("t6_rst_resp", mem_resp, 1'b0);
    chk_b("t6_rst_empty", empty, 1'b1);
    flush = 1'b0;
    fixed_wait = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      flush = ($urandom_range(0, 7) == 0);
      if (op < 5) begin
        a = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd32;
        do_write(a, rnd_line(), lat);
      end else if (op < 8) begin
        a = 32'h1000 + 32'($urandom_range(0, 11)) * 32'd32;
        do_read(a, d, lat);
      end else begin
        idle(int'($urandom_range(1, 4)));
      end
    end
    flush = 1'b1;
    wait_empty("final_empty");
    flush = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/ewb_multi.md
Name: ewb_multi

Overview:
- Parametrised multi-entry eviction write buffer between the L2 cache and physical memory.
- Accepts dirty-line writebacks in one cycle and holds up to DEPTH lines in FIFO order.
- Serves reads that hit buffered lines and merges repeat writes to the same line.
- Drains to memory when full, after an idle window, or on an explicit flush; read misses pass through to memory.

Parameters:
DEPTH, 4, number of buffered lines (power of two, >=2)
ADDR_W, 32, address width
LINE_W, 256, cache line width
IDLE_CYC, 2, consecutive idle upstream cycles before a non-full drain starts (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
mem_address  in  ADDR_W  L2 request line address
mem_rdata  out  LINE_W  read data to L2
mem_wdata  in  LINE_W  writeback data from L2
mem_read  in  1  L2 read request, held until mem_resp
mem_write  in  1  L2 write request, held until mem_resp
mem_resp  out  1  request complete, 1-cycle pulse per request
flush  in  1  level; drain every entry while high
empty  out  1  no valid entries
pmem_address  out  ADDR_W  memory address
pmem_rdata  in  LINE_W  memory read data
pmem_wdata  out  LINE_W  memory write data
pmem_read  out  1  memory read
pmem_write  out  1  memory write
pmem_resp  in  1  memory completion

Behaviour:
- Storage: DEPTH entries of {valid, addr, data}; head/tail pointers wrap modulo DEPTH; count is 0..DEPTH; full = (count==DEPTH).
- Reset (rst low, async):
  - all valid bits, pointers, count and idle counter cleared; state IDLE.
  - mem_resp, pmem_read and pmem_write are 0; mem_rdata, pmem_address and pmem_wdata are 0; empty is 1.
- Hit: mem_address equals the addr of any valid entry. At most one entry matches, guaranteed by coalescing.
- mem_read and mem_write together is illegal; the bench asserts on it.
- States:
  - IDLE: no memory transaction.
  - PASS: read miss in flight.
  - DRAIN: head entry being written.
- Write, hit, and the matching entry is not the head during DRAIN: overwrite its data; mem_resp in the same cycle (0 latency); count unchanged.
- Write, miss, not full: allocate at tail; tail++, count++; mem_resp in the same cycle.
- Write, miss, full: no mem_resp; stall until a DRAIN completion frees a slot. In that completion cycle, the freed slot is allocated and mem_resp is asserted.
- Write hitting the head during DRAIN: stall until the drain completes, then allocate as a fresh miss. pmem_wdata stays stable throughout the drain.
- Read, hit (any state): mem_rdata = entry data; mem_resp in the same cycle; no pmem activity.
- Read, miss, state IDLE:
  - enter PASS; pmem_read=1, pmem_address=mem_address.
  - mem_rdata = pmem_rdata, mem_resp = pmem_resp; return to IDLE on pmem_resp.
- Read, miss, state DRAIN: wait; start PASS in the cycle after the drain completes.
- Idle counter: increments on cycles with no mem_read/mem_write and saturates at IDLE_CYC; cleared by any request.
- Drain start: IDLE -> DRAIN when count>0 and (full, or idle counter == IDLE_CYC, or flush).
  - A pending read miss in IDLE takes priority, unless full.
- DRAIN:
  - pmem_write=1, pmem_address/pmem_wdata = head entry.
  - On pmem_resp: clear head valid, head++, count--, go to IDLE.
  - A new drain may start the next cycle.
- pmem_read and pmem_write are never high together, and are never high outside PASS/DRAIN.
- Simultaneous drain completion and write allocate: count is net unchanged; pointers update independently.
- empty is a registered-equivalent of count==0.
- Reset mid-DRAIN or mid-PASS: the transaction is abandoned and buffered data is lost. This is legal only at system reset.

Decomposition:
- Package ewb_pkg holds the state enum {IDLE, PASS, DRAIN} and the entry struct type parameterised by ADDR_W and LINE_W. Default widths live there as constants.
- Sub-module ewb_cam: combinational DEPTH-way address compare. Outputs hit, a one-hot match vector and the encoded index.

Test Plan:
- Reset then write 0x100/D0 -> mem_resp same cycle, empty=0. After 2 idle cycles: pmem_write with addr 0x100/D0; on pmem_resp, empty=1.
- Write 0x100/D0, then write 0x100/D1 before the drain starts -> count stays 1. Exactly one pmem_write occurs, with data D1.
- Fill 4 lines 0x000/0x020/0x040/0x060, then write 0x080:
  - no mem_resp until the first pmem_resp;
  - the drain order is 0x000 first;
  - 0x080 is accepted in the completion cycle.
- Buffered 0x040/DA; read 0x040 -> mem_rdata=DA, mem_resp same cycle, pmem_read never asserted. Read 0x200 -> pmem_read with addr 0x200; mem_resp follows pmem_resp.
- Read miss 0x300 issued while a drain of 0x000 is in flight -> pmem_read only after the drain's pmem_resp. The pmem_read and pmem_write strobes never overlap.
- 3 entries, flush held high -> 3 back-to-back pmem_writes in FIFO order, then empty=1. Then assert rst low mid-DRAIN -> outputs go to 0 and empty goes to 1 immediately, without waiting for a clock edge.
